// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the RV32IM register file: ALU writeback vs. MUL/DIV results,
// with a MUL/DIV destination scoreboard for hazard stalls. Optional starvation guard: WB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_wr_en,
  input  logic [4:0]      alu_rd_address,
  input  logic [XLEN-1:0] alu_rd_data,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_rd_address,
  input  logic [XLEN-1:0] md_rd_data,
  input  logic            rd_rs1_en,
  input  logic [4:0]      rs1_address,
  input  logic            rd_rs2_en,
  input  logic [4:0]      rs2_address,
  input  logic            dec_rd_en,
  input  logic [4:0]      dec_rd_address,
  output logic            stall_reg_rd,
  output logic            alu_hold,
  output logic            wr_rd_en,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] rd_data
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;

  // ALU can never be back-pressured, so it always wins the port.
  assign md_ready = md_valid & ~alu_wr_en;

  // Stall looks only at registered busy bits; a clearing write lands on the port next cycle.
  assign stall_reg_rd = (rd_rs1_en & busy_q[rs1_address])
                      | (rd_rs2_en & busy_q[rs2_address])
                      | (dec_rd_en & busy_q[dec_rd_address]);

  always_comb begin
    wr_en_d = alu_wr_en | md_ready;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    if (alu_wr_en) begin
      addr_d = alu_rd_address;
      data_d = alu_rd_data;
    end else if (md_valid) begin
      addr_d = md_rd_address;
      data_d = md_rd_data;
    end
    if (md_ready) busy_d[md_rd_address] = 1'b0;
    // A new issue to the same register outranks the retiring result.
    if (md_issue && (md_issue_rd != '0)) busy_d[md_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_rd_en   = wr_en_q;
  assign rd_address = addr_q;
  assign rd_data    = data_q;

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;

  // Count cycles a MUL/DIV result waits; request an ALU bubble once the limit is reached.
  always_comb begin
    starve_d = starve_q;
    if (md_ready) begin
      starve_d = '0;
    end else if (md_valid && (starve_q != CW'(STARVE_MAX))) begin
      starve_d = starve_q + CW'(1);
    end
    hold_d = (starve_d == CW'(STARVE_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  assign alu_hold = hold_q;

  a_no_alu_during_hold: assert property (@(posedge clk) disable iff (reset) !(alu_wr_en && hold_q));
`else
  assign alu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model (pending-register set, priority rule, wait counter).
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_wr_en;
  logic [4:0]      alu_rd_address;
  logic [XLEN-1:0] alu_rd_data;
  logic            md_issue;
  logic [4:0]      md_issue_rd;
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd_address;
  logic [XLEN-1:0] md_rd_data;
  logic            rd_rs1_en;
  logic [4:0]      rs1_address;
  logic            rd_rs2_en;
  logic [4:0]      rs2_address;
  logic            dec_rd_en;
  logic [4:0]      dec_rd_address;
  logic            stall_reg_rd;
  logic            alu_hold;
  logic            wr_rd_en;
  logic [4:0]      rd_address;
  logic [XLEN-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .alu_wr_en(alu_wr_en), .alu_rd_address(alu_rd_address), .alu_rd_data(alu_rd_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd_address(md_rd_address), .md_rd_data(md_rd_data),
    .rd_rs1_en(rd_rs1_en), .rs1_address(rs1_address),
    .rd_rs2_en(rd_rs2_en), .rs2_address(rs2_address),
    .dec_rd_en(dec_rd_en), .dec_rd_address(dec_rd_address),
    .stall_reg_rd(stall_reg_rd), .alu_hold(alu_hold),
    .wr_rd_en(wr_rd_en), .rd_address(rd_address), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wr_en = 1'b0; alu_rd_address = '0; alu_rd_data = '0;
    md_issue = 1'b0; md_issue_rd = '0;
    md_valid = 1'b0; md_rd_address = '0; md_rd_data = '0;
    rd_rs1_en = 1'b0; rs1_address = '0;
    rd_rs2_en = 1'b0; rs2_address = '0;
    dec_rd_en = 1'b0; dec_rd_address = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (wr_rd_en !== 1'b0 || rd_address !== 5'd0 || rd_data !== '0 || alu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h hold=%b, want 0 0 0 0",
               wr_rd_en, rd_address, rd_data, alu_hold);
    end
    for (int r = 0; r < 32; r++) begin
      rd_rs1_en = 1'b1; rs1_address = 5'(r);
      rd_rs2_en = 1'b1; rs2_address = 5'(31 - r);
      dec_rd_en = 1'b1; dec_rd_address = 5'(r);
      #1;
      checks++;
      if (stall_reg_rd !== 1'b0 || md_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_stall r=%0d: got stall=%b md_ready=%b, want 0 0", r, stall_reg_rd, md_ready);
      end
    end
    idle();
  endtask

  task automatic test_alu_write();
    alu_wr_en = 1'b1; alu_rd_address = 5'd5; alu_rd_data = 32'hDEADBEEF;
    tick();
    idle();
    checks++;
    if (wr_rd_en !== 1'b1 || rd_address !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write: got en=%b addr=%0d data=%h, want 1 5 deadbeef", wr_rd_en, rd_address, rd_data);
    end
    tick();
    checks++;
    if (wr_rd_en !== 1'b0 || rd_address !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_hold: got en=%b addr=%0d data=%h, want 0 5 deadbeef", wr_rd_en, rd_address, rd_data);
    end
  endtask

  task automatic test_conflict();
    alu_wr_en = 1'b1; alu_rd_address = 5'd3; alu_rd_data = 32'h0000_0333;
    md_valid = 1'b1; md_rd_address = 5'd7; md_rd_data = 32'h7777_0007;
    #1;
    checks++;
    if (md_ready !== 1'b0) begin
      errors++; $display("FAIL conflict_md_ready: got %b want 0", md_ready);
    end
    tick();
    checks++;
    if (wr_rd_en !== 1'b1 || rd_address !== 5'd3 || rd_data !== 32'h0000_0333) begin
      errors++;
      $display("FAIL conflict_alu_wins: got en=%b addr=%0d data=%h, want 1 3 00000333", wr_rd_en, rd_address, rd_data);
    end
    alu_wr_en = 1'b0;
    #1;
    checks++;
    if (md_ready !== 1'b1) begin
      errors++; $display("FAIL conflict_md_served: got md_ready=%b want 1", md_ready);
    end
    tick();
    md_valid = 1'b0;
    checks++;
    if (wr_rd_en !== 1'b1 || rd_address !== 5'd7 || rd_data !== 32'h7777_0007) begin
      errors++;
      $display("FAIL conflict_md_write: got en=%b addr=%0d data=%h, want 1 7 77770007", wr_rd_en, rd_address, rd_data);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick();
    md_issue = 1'b0;
    rd_rs1_en = 1'b1; rs1_address = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (stall_reg_rd !== 1'b1) begin
        errors++; $display("FAIL sb_stall k=%0d: got %b want 1", k, stall_reg_rd);
      end
      tick();
    end
    md_valid = 1'b1; md_rd_address = 5'd9; md_rd_data = 32'h0000_0099;
    #1;
    checks++;
    if (stall_reg_rd !== 1'b1 || md_ready !== 1'b1) begin
      errors++; $display("FAIL sb_accept_cycle: got stall=%b ready=%b want 1 1", stall_reg_rd, md_ready);
    end
    tick();
    md_valid = 1'b0;
    #1;
    checks++;
    if (stall_reg_rd !== 1'b0 || wr_rd_en !== 1'b1 || rd_address !== 5'd9 || rd_data !== 32'h0000_0099) begin
      errors++;
      $display("FAIL sb_released: got stall=%b en=%b addr=%0d data=%h, want 0 1 9 00000099",
               stall_reg_rd, wr_rd_en, rd_address, rd_data);
    end
    idle();
  endtask

  task automatic test_x0();
    md_issue = 1'b1; md_issue_rd = 5'd0;
    tick();
    md_issue = 1'b0;
    rd_rs1_en = 1'b1; rs1_address = 5'd0;
    dec_rd_en = 1'b1; dec_rd_address = 5'd0;
    #1;
    checks++;
    if (stall_reg_rd !== 1'b0) begin
      errors++; $display("FAIL x0_no_stall: got %b want 0", stall_reg_rd);
    end
    idle();
    alu_wr_en = 1'b1; alu_rd_address = 5'd0; alu_rd_data = 32'h1234_5678;
    tick();
    idle();
    checks++;
    if (wr_rd_en !== 1'b1 || rd_address !== 5'd0 || rd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL x0_passthrough: got en=%b addr=%0d data=%h, want 1 0 12345678", wr_rd_en, rd_address, rd_data);
    end
  endtask

  task automatic test_set_clear_same();
    md_issue = 1'b1; md_issue_rd = 5'd12;
    tick();
    md_valid = 1'b1; md_rd_address = 5'd12; md_rd_data = 32'hC0C0_0012;
    tick();
    idle();
    rd_rs2_en = 1'b1; rs2_address = 5'd12;
    #1;
    checks++;
    if (stall_reg_rd !== 1'b1) begin
      errors++; $display("FAIL set_wins_clear: got stall=%b want 1", stall_reg_rd);
    end
    alu_wr_en = 1'b1; alu_rd_address = 5'd4; alu_rd_data = 32'hAAAA_5555;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alu_wr_en = 1'b0;
    #1;
    checks++;
    if (stall_reg_rd !== 1'b0 || wr_rd_en !== 1'b0 || rd_address !== 5'd0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_midop: got stall=%b en=%b addr=%0d data=%h, want 0 0 0 0",
               stall_reg_rd, wr_rd_en, rd_address, rd_data);
    end
    idle();
  endtask

  task automatic test_starve();
    do_reset();
    alu_wr_en = 1'b1; alu_rd_address = 5'd1; alu_rd_data = 32'h1;
    md_valid = 1'b1; md_rd_address = 5'd20; md_rd_data = 32'h2020_2020;
    for (int k = 0; k < 4; k++) begin
      alu_rd_data = 32'(k);
      #1;
      checks++;
      if (md_ready !== 1'b0 || alu_hold !== 1'b0) begin
        errors++; $display("FAIL starve_wait k=%0d: got ready=%b hold=%b want 0 0", k, md_ready, alu_hold);
      end
      tick();
    end
`ifdef WB_STARVE_GUARD_EN
    checks++;
    if (alu_hold !== 1'b1) begin
      errors++; $display("FAIL starve_hold: got %b want 1", alu_hold);
    end
    alu_wr_en = 1'b0;
    #1;
    checks++;
    if (md_ready !== 1'b1) begin
      errors++; $display("FAIL starve_md_ready: got %b want 1", md_ready);
    end
    tick();
    md_valid = 1'b0;
    checks++;
    if (alu_hold !== 1'b0 || wr_rd_en !== 1'b1 || rd_address !== 5'd20 || rd_data !== 32'h2020_2020) begin
      errors++;
      $display("FAIL starve_release: got hold=%b en=%b addr=%0d data=%h, want 0 1 20 20202020",
               alu_hold, wr_rd_en, rd_address, rd_data);
    end
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (md_ready !== 1'b0 || alu_hold !== 1'b0) begin
        errors++; $display("FAIL no_guard_wait k=%0d: got ready=%b hold=%b want 0 0", k, md_ready, alu_hold);
      end
      tick();
    end
`endif
    idle();
  endtask

  // Reference model: set of registers awaiting a MUL/DIV result, last write on the port, wait count.
  task automatic test_random();
    bit              pend[32];
    bit              e_en;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;
    int              waited;
    bit              e_hold;
    bit              e_ready, e_stall;
    do_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    e_en = 1'b0; e_addr = '0; e_data = '0; waited = 0; e_hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset          = ($urandom_range(0, 59) == 0);
      alu_wr_en      = e_hold ? 1'b0 : 1'($urandom_range(0, 1));
      alu_rd_address = 5'($urandom);
      alu_rd_data    = $urandom;
      md_issue       = ($urandom_range(0, 2) == 0);
      md_issue_rd    = 5'($urandom_range(0, 7));
      md_valid       = ($urandom_range(0, 2) == 0);
      md_rd_address  = 5'($urandom_range(0, 7));
      md_rd_data     = $urandom;
      rd_rs1_en      = 1'($urandom_range(0, 1));
      rs1_address    = 5'($urandom_range(0, 8));
      rd_rs2_en      = 1'($urandom_range(0, 1));
      rs2_address    = 5'($urandom_range(0, 8));
      dec_rd_en      = 1'($urandom_range(0, 1));
      dec_rd_address = 5'($urandom_range(0, 8));
      e_ready = md_valid && !alu_wr_en;
      e_stall = (rd_rs1_en && pend[rs1_address]) || (rd_rs2_en && pend[rs2_address])
             || (dec_rd_en && pend[dec_rd_address]);
      #1;
      checks++;
      if (md_ready !== e_ready || stall_reg_rd !== e_stall) begin
        errors++;
        $display("FAIL rand_comb cyc=%0d: got ready=%b stall=%b, want %b %b", cyc, md_ready, stall_reg_rd, e_ready, e_stall);
      end
      if (reset) begin
        foreach (pend[i]) pend[i] = 1'b0;
        e_en = 1'b0; e_addr = '0; e_data = '0; waited = 0; e_hold = 1'b0;
      end else begin
        e_en = alu_wr_en || md_valid;
        if (alu_wr_en) begin
          e_addr = alu_rd_address; e_data = alu_rd_data;
        end else if (md_valid) begin
          e_addr = md_rd_address; e_data = md_rd_data;
        end
        if (e_ready) pend[md_rd_address] = 1'b0;
        if (md_issue && md_issue_rd != 5'd0) pend[md_issue_rd] = 1'b1;
`ifdef WB_STARVE_GUARD_EN
        if (e_ready) waited = 0;
        else if (md_valid && waited < STARVE_MAX) waited++;
        e_hold = (waited == STARVE_MAX);
`endif
      end
      tick();
      checks++;
      if (wr_rd_en !== e_en || rd_address !== e_addr || rd_data !== e_data || alu_hold !== e_hold) begin
        errors++;
        $display("FAIL rand_port cyc=%0d: got en=%b addr=%0d data=%h hold=%b, want %b %0d %h %b",
                 cyc, wr_rd_en, rd_address, rd_data, alu_hold, e_en, e_addr, e_data, e_hold);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_write();
    test_conflict();
    test_scoreboard();
    test_x0();
    test_set_clear_same();
    test_starve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
